snake_body_fifo: RTL and testbench

Parametrised circular queue holding snake body segment coordinates, sitting between the game-step controller and the renderer/collision logic. Next generation of the team's body FIFO: configurable data width, depth and preloaded initial length. Adds independent push/pop so the snake can grow, plus full/empty/count status and sticky error flags. Includes a built-in occupancy scan engine that searches the live body for a coordinate (self-collision check).

---
 rtl/snake_pkg.sv | 19 +
 rtl/snake_body_scanner.sv | 101 ++++++++++
 rtl/snake_body_fifo.sv | 122 ++++++++++++
 tb/tb_snake_body_fifo.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared defaults and scan-engine state encoding for the snake
// body FIFO family.
//   SNAKE_DATA_W   default segment word width (packed x/y coordinate)
//   SNAKE_ADDR_W   default pointer width, queue depth is 2**ADDR_W
//   SNAKE_INIT_LEN default number of segments preloaded at reset
//   scan_state_t   occupancy-scan FSM states
package snake_pkg;

  localparam int SNAKE_DATA_W   = 8;
  localparam int SNAKE_ADDR_W   = 7;
  localparam int SNAKE_INIT_LEN = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/snake_body_scanner.sv
// snake_body_scanner: walks the live body one entry per cycle looking for a
// coordinate (self-collision check).
//   clk, aclr     clock, asynchronous active-high reset
//   scan_start    start request, ignored while busy
//   scan_key      coordinate to search for
//   head_ptr      current read pointer of the FIFO (oldest segment)
//   live_count    current occupancy of the FIFO
//   scan_addr     address presented to the FIFO's scan read port
//   scan_data     memory word at scan_addr (combinational)
//   scan_busy     high while the engine is not idle
//   scan_done     one-cycle pulse, scan_hit valid
//   scan_hit      key found, held until the next scan_done
module snake_body_scanner
  import snake_pkg::*;
#(
  parameter int DATA_W = SNAKE_DATA_W,
  parameter int ADDR_W = SNAKE_ADDR_W
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              scan_start,
  input  logic [DATA_W-1:0] scan_key,
  input  logic [ADDR_W-1:0] head_ptr,
  input  logic [ADDR_W:0]   live_count,
  output logic [ADDR_W-1:0] scan_addr,
  input  logic [DATA_W-1:0] scan_data,
  output logic              scan_busy,
  output logic              scan_done,
  output logic              scan_hit
);

  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);

  scan_state_t       state, state_nx;
  logic [DATA_W-1:0] key_q, key_nx;
  logic [ADDR_W-1:0] idx_q, idx_nx;
  logic [ADDR_W:0]   rem_q, rem_nx;
  logic              hit_q, hit_nx;
  logic              match;

  assign match = (scan_data == key_q);

  always_comb begin
    state_nx = state;
    key_nx   = key_q;
    idx_nx   = idx_q;
    rem_nx   = rem_q;
    hit_nx   = hit_q;
    case (state)
      S_IDLE: begin
        if (scan_start) begin
          key_nx = scan_key;
          idx_nx = head_ptr;
          // The scan length is frozen here; pushes and pops that happen
          // while scanning do not extend or shorten it.
          rem_nx = live_count;
          if (live_count == '0) begin
            hit_nx   = 1'b0;
            state_nx = S_DONE;
          end else begin
            state_nx = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        idx_nx = idx_q + IDX_ONE;
        rem_nx = rem_q - REM_ONE;
        if (match || rem_q == REM_ONE) begin
          hit_nx   = match;
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state <= S_IDLE;
      hit_q <= 1'b0;
    end else begin
      state <= state_nx;
      hit_q <= hit_nx;
    end
  end

  // Key and walk counters are only meaningful while scanning.
  always_ff @(posedge clk) begin
    key_q <= key_nx;
    idx_q <= idx_nx;
    rem_q <= rem_nx;
  end

  assign scan_addr = idx_q;
  assign scan_busy = (state != S_IDLE);
  assign scan_done = (state == S_DONE);
  assign scan_hit  = hit_q;

endmodule

// File: rtl/snake_body_fifo.sv
// snake_body_fifo: circular queue of snake body segment coordinates with
// independent push (new head) and pop (tail), occupancy status, sticky
// error flags and a built-in occupancy scan engine.
//   clk, aclr            clock, asynchronous active-high reset
//   rdenable             pop request
//   wrenable, datain     push request and data
//   dataout, dout_valid  registered popped word and its one-cycle strobe
//   full, empty, count   occupancy status
//   ovf_err, udf_err     sticky: rejected push / rejected pop
//   scan_start, scan_key start a search of the live body for scan_key
//   scan_busy, scan_done, scan_hit  scan engine status and result
module snake_body_fifo
  import snake_pkg::*;
#(
  parameter int DATA_W   = SNAKE_DATA_W,
  parameter int ADDR_W   = SNAKE_ADDR_W,
  parameter int INIT_LEN = SNAKE_INIT_LEN
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              rdenable,
  input  logic              wrenable,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err,
  output logic              udf_err,
  input  logic              scan_start,
  input  logic [DATA_W-1:0] scan_key,
  output logic              scan_busy,
  output logic              scan_done,
  output logic              scan_hit
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_INIT = (ADDR_W+1)'(INIT_LEN);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] WR_INIT  = ADDR_W'(INIT_LEN % DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rdptr, wrptr;
  logic [ADDR_W:0]   count_q;
  logic              pop_ok, push_ok;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign count = count_q;

  // A full queue still takes a push when the tail leaves in the same cycle;
  // an empty queue never bypasses a push straight to dataout.
  assign pop_ok  = rdenable && !empty;
  assign push_ok = wrenable && (!full || pop_ok);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < INIT_LEN) ? DATA_W'(i) : '0;
      end
    end else if (push_ok) begin
      mem[wrptr] <= datain;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rdptr      <= '0;
      wrptr      <= WR_INIT;
      count_q    <= CNT_INIT;
      dataout    <= '0;
      dout_valid <= 1'b0;
      ovf_err    <= 1'b0;
      udf_err    <= 1'b0;
    end else begin
      dout_valid <= pop_ok;
      if (pop_ok) begin
        dataout <= mem[rdptr];
        rdptr   <= rdptr + PTR_ONE;
      end
      if (push_ok) begin
        wrptr <= wrptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (wrenable && !push_ok) begin
        ovf_err <= 1'b1;
      end
      if (rdenable && !pop_ok) begin
        udf_err <= 1'b1;
      end
    end
  end

  assign scan_data = mem[scan_addr];

  snake_body_scanner #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_scanner (
    .clk        (clk),
    .aclr       (aclr),
    .scan_start (scan_start),
    .scan_key   (scan_key),
    .head_ptr   (rdptr),
    .live_count (count_q),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done),
    .scan_hit   (scan_hit)
  );

endmodule

// File: tb/tb_snake_body_fifo.sv
// tb_snake_body_fifo: scoreboard bench for snake_body_fifo. The reference
// model is a plain queue of live segments plus a slot array for what each
// storage position holds; expected pops and scan results are queued and a
// negedge monitor checks them as the DUT presents them.
module tb_snake_body_fifo;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int IL = 3;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          rdenable = 1'b0;
  logic          wrenable = 1'b0;
  logic          scan_start = 1'b0;
  logic [DW-1:0] datain = '0;
  logic [DW-1:0] scan_key = '0;
  logic [DW-1:0] dataout;
  logic          dout_valid, full, empty, ovf_err, udf_err;
  logic          scan_busy, scan_done, scan_hit;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // reference model state
  int  mq[$];
  int  slot[D];
  int  rpos, wpos;
  bit  m_ovf, m_udf, m_dv, m_hit;
  int  m_dout;
  bit  scanning, done_lock;
  int  sbase, sn, sidx, skey;
  int  cyc = 0;

  typedef struct {
    int at_edge;
    bit hit;
  } scan_exp_t;

  int        exp_data[$];
  scan_exp_t exp_scan[$];

  snake_body_fifo #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .INIT_LEN (IL)
  ) dut (
    .clk        (clk),
    .aclr       (aclr),
    .rdenable   (rdenable),
    .wrenable   (wrenable),
    .datain     (datain),
    .dataout    (dataout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err),
    .scan_start (scan_start),
    .scan_key   (scan_key),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done),
    .scan_hit   (scan_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at step %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_data.delete();
    exp_scan.delete();
    for (int i = 0; i < D; i++) slot[i] = (i < IL) ? i : 0;
    for (int i = 0; i < IL; i++) mq.push_back(i);
    rpos = 0;
    wpos = IL;
    m_ovf = 0; m_udf = 0; m_dv = 0; m_hit = 0; m_dout = 0;
    scanning = 0; done_lock = 0;
  endtask

  // One rising edge of the reference model.
  task automatic model_edge(input bit rd, input bit wr, input int din,
                            input bit ss, input int key);
    int cnt;
    bit pop_ok, push_ok, m;
    scan_exp_t e;
    cnt = mq.size();
    cyc++;
    // scan compares see storage as it was before this edge's push
    if (scanning) begin
      m = (slot[(sbase + sidx) % D] == skey);
      sidx++;
      if (m || sidx == sn) begin
        e.at_edge = cyc; e.hit = m;
        exp_scan.push_back(e);
        m_hit = m;
        scanning = 0;
        done_lock = 1;
      end
    end else if (done_lock) begin
      done_lock = 0;
    end else if (ss) begin
      if (cnt == 0) begin
        e.at_edge = cyc; e.hit = 0;
        exp_scan.push_back(e);
        m_hit = 0;
        done_lock = 1;
      end else begin
        scanning = 1; sbase = rpos; sn = cnt; sidx = 0; skey = key;
      end
    end
    pop_ok  = rd && (cnt > 0);
    push_ok = wr && ((cnt < D) || pop_ok);
    m_dv = pop_ok;
    if (pop_ok) begin
      m_dout = mq.pop_front();
      exp_data.push_back(m_dout);
      rpos++;
    end else if (rd) begin
      m_udf = 1;
    end
    if (push_ok) begin
      mq.push_back(din);
      slot[wpos % D] = din;
      wpos++;
    end else if (wr) begin
      m_ovf = 1;
    end
  endtask

  task automatic step(input bit rd, input bit wr, input int din,
                      input bit ss, input int key);
    rdenable = rd; wrenable = wr; datain = DW'(din);
    scan_start = ss; scan_key = DW'(key);
    @(posedge clk);
    model_edge(rd, wr, din, ss, key);
    @(negedge clk);
    rdenable = 0; wrenable = 0; scan_start = 0;
  endtask

  task automatic do_reset();
    #2 aclr = 1'b1;
    #1 model_reset();
    chk("rst_count", count, IL);
    chk("rst_empty", empty, 0);
    chk("rst_full", full, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_udf", udf_err, 0);
    chk("rst_scan_busy", scan_busy, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_scan_hit", scan_hit, 0);
    @(posedge clk);
    @(negedge clk);
    #2 aclr = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic do_scan(input int key, input int exp_lat, input int exp_hit,
                         input string nm);
    int lat;
    lat = 1;
    step(0, 0, 0, 1, key);
    while (!scan_done && lat < 20) begin
      step(0, 0, 0, 0, 0);
      lat++;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_hit"}, scan_hit, exp_hit);
    step(0, 0, 0, 0, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && !aclr) begin
      chk("count", count, mq.size());
      chk("empty", empty, int'(mq.size() == 0));
      chk("full", full, int'(mq.size() == D));
      chk("ovf_err", ovf_err, m_ovf);
      chk("udf_err", udf_err, m_udf);
      chk("dout_valid", dout_valid, m_dv);
      chk("dataout_hold", dataout, m_dout);
      chk("scan_busy", scan_busy, int'(scanning || done_lock));
      chk("scan_hit_held", scan_hit, m_hit);
      if (dout_valid) begin
        if (exp_data.size() == 0) chk("dout_spurious", dout_valid, 0);
        else chk("pop_data", dataout, exp_data.pop_front());
      end
      if (scan_done) begin
        if (exp_scan.size() == 0) begin
          chk("scan_done_spurious", scan_done, 0);
        end else begin
          scan_exp_t e;
          e = exp_scan.pop_front();
          chk("scan_done_step", cyc, e.at_edge);
          chk("scan_result", scan_hit, e.hit);
        end
      end else if (exp_scan.size() > 0 && exp_scan[0].at_edge <= cyc) begin
        chk("scan_done_missing", scan_done, 1);
        void'(exp_scan.pop_front());
      end
    end
  end

  initial begin
    int key;
    bit rd, wr, ss;
    @(negedge clk);

    // reset contents and underflow
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("udf_after_4th_pop", udf_err, 1);
    chk("dataout_stays_2", dataout, 2);

    // growth
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 8'h10 + i, 0, 0);
    chk("count_growth", count, 8);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
    chk("empty_after_growth_drain", empty, 1);

    // wrap, overflow, push+pop at full
    for (int i = 0; i < D; i++) step(0, 1, 8'h21 + i, 0, 0);
    chk("full_after_fill", full, 1);
    step(0, 1, 8'h30, 0, 0);
    chk("ovf_on_extra_push", ovf_err, 1);
    chk("count_after_ovf", count, D);
    for (int i = 0; i < 20; i++) step(1, 1, 8'h40 + i, 0, 0);
    chk("count_pushpop_full", count, D);

    // push+pop on empty
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 8'h55, 0, 0);
    chk("empty_pushpop_count", count, 1);
    chk("empty_pushpop_dv", dout_valid, 0);
    chk("empty_pushpop_udf", udf_err, 1);
    step(1, 0, 0, 0, 0);
    chk("empty_pushpop_data", dataout, 8'h55);

    // scans
    do_reset();
    do_scan(2, 4, 1, "scan_key2");
    do_scan(8'h7F, 4, 0, "scan_miss");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    do_scan(5, 1, 0, "scan_empty");

    // reset mid-scan and mid-stream
    do_reset();
    step(0, 1, 8'h61, 0, 0);
    step(0, 1, 8'h62, 0, 0);
    step(0, 0, 0, 1, 8'hEE);
    step(1, 0, 0, 0, 0);
    step(1, 1, 8'h63, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 0, 0, 0);
    chk("pop_after_midstream_reset", dataout, 0);

    // randomized traffic with concurrent scans
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      rd = ($urandom_range(0, 99) < 45);
      wr = ($urandom_range(0, 99) < 50);
      ss = ($urandom_range(0, 99) < 10);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        key = mq[$urandom_range(0, mq.size() - 1)];
      else
        key = $urandom_range(0, 255);
      step(rd, wr, $urandom_range(0, 255), ss, key);
    end

    for (int i = 0; i < D + 3; i++) step(0, 0, 0, 0, 0);
    chk("pending_pops", exp_data.size(), 0);
    chk("pending_scans", exp_scan.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
